// File: rtl/nios_practica_timer_ctl_master_if.sv
// Avalon-MM point-to-point link between the timer controller (master) and
// the interval timer s1 slave port.
//   address/chipselect/write_n/writedata : master -> timer
//   readdata (registered, one cycle after address), irq (level) : timer -> master
interface nios_practica_timer_ctl_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/nios_practica_timer_ctl_master.sv
// Hardware initiator that programs and services the 16-bit-register interval
// timer: loads a 32-bit period, starts the timer, clears every timeout and
// reports ticks to fabric logic.
// Ports:
//   clk, reset      : clock, async active-high reset
//   start/period    : pulse to latch period and (re)program the timer
//   stop            : pulse to halt the timer
//   snap_req        : pulse to capture the live counter (snapshot build only)
//   bus             : Avalon-MM master to the timer s1 port
//   busy            : FSM outside IDLE/RUN
//   running         : timer believed running
//   tick/tick_count : one pulse / wrapping count per serviced timeout
//   snapshot/snap_valid : captured counter value and its update pulse
// Optional feature: define TIMER_CTL_SNAPSHOT_EN to include the counter
// snapshot sequence; otherwise snap_req is ignored and snapshot reads 0.
module nios_practica_timer_ctl_master #(
  parameter int TICK_W     = 16,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         period,
  input  logic                stop,
  input  logic                snap_req,
  nios_practica_timer_ctl_master_if.master bus,
  output logic                busy,
  output logic                running,
  output logic                tick,
  output logic [TICK_W-1:0]   tick_count,
  output logic [31:0]         snapshot,
  output logic                snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, STOP_WR
`ifdef TIMER_CTL_SNAPSHOT_EN
    , SNAP_WR, SNAP_RL, SNAP_RLW, SNAP_RH, SNAP_RHW
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] period_hi_q;   // only the high half is needed after WR_PL
  logic        stop_clr_q, stop_clr_d;  // CLR_ST reached via stop: no tick
  logic        skip_irq_q, skip_irq_d;  // ignore irq in first RUN cycle after CLR_ST
  logic        running_d;
  logic        period_ld, cnt_clr, cnt_inc;
  logic        snap_lo_ld, snap_hi_ld;
  logic        cs_d, wn_d;
  logic [2:0]  addr_d;
  logic [15:0] wd_d;

  always_comb begin
    state_d    = state_q;
    stop_clr_d = stop_clr_q;
    skip_irq_d = 1'b0;
    running_d  = running;
    period_ld  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    snap_lo_ld = 1'b0;
    snap_hi_ld = 1'b0;
    case (state_q)
      IDLE:    if (start) begin
                 state_d = WR_PL; period_ld = 1'b1; cnt_clr = 1'b1;
               end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTL;
      WR_CTL:  begin state_d = RUN; running_d = 1'b1; end
      RUN: begin
        if (stop) begin
          state_d = STOP_WR; running_d = 1'b0;
        end else if (bus.irq && !skip_irq_q) begin
          state_d = CLR_ST; stop_clr_d = 1'b0; cnt_inc = 1'b1;
`ifdef TIMER_CTL_SNAPSHOT_EN
        end else if (snap_req) begin
          state_d = SNAP_WR;
`endif
        end else if (start) begin
          state_d = WR_PL; period_ld = 1'b1; cnt_clr = 1'b1;
        end
      end
      CLR_ST: begin
        if (stop_clr_q || !CONTINUOUS) begin
          state_d = IDLE; running_d = 1'b0;
        end else begin
          state_d = RUN; skip_irq_d = 1'b1;
        end
      end
      STOP_WR: begin state_d = CLR_ST; stop_clr_d = 1'b1; end
`ifdef TIMER_CTL_SNAPSHOT_EN
      SNAP_WR:  state_d = SNAP_RL;
      SNAP_RL:  state_d = SNAP_RLW;
      SNAP_RLW: begin state_d = SNAP_RH; snap_lo_ld = 1'b1; end
      SNAP_RH:  state_d = SNAP_RHW;
      SNAP_RHW: begin state_d = RUN; snap_hi_ld = 1'b1; end
`endif
      default:  state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so each bus phase
    // lines up with the cycle the FSM spends in that state.
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'h0;
    case (state_d)
      WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period[15:0]; end
      WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_hi_q; end
      // control: STOP=0, START=1, CONT, ITO=1
      WR_CTL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
                     wd_d = {12'h0, 1'b0, 1'b1, CONTINUOUS, 1'b1}; end
      CLR_ST:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
      STOP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008; end
`ifdef TIMER_CTL_SNAPSHOT_EN
      SNAP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
      SNAP_RL: begin cs_d = 1'b1; addr_d = 3'd4; end
      SNAP_RH: begin cs_d = 1'b1; addr_d = 3'd5; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      period_hi_q    <= '0;
      stop_clr_q     <= 1'b0;
      skip_irq_q     <= 1'b0;
      running        <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      bus.address    <= 3'd0;
      bus.writedata  <= 16'h0;
    end else begin
      state_q        <= state_d;
      stop_clr_q     <= stop_clr_d;
      skip_irq_q     <= skip_irq_d;
      running        <= running_d;
      tick           <= cnt_inc;
      if (period_ld) period_hi_q <= period[31:16];
      if (cnt_clr)      tick_count <= '0;
      else if (cnt_inc) tick_count <= tick_count + 1'b1;
      bus.chipselect <= cs_d;
      bus.write_n    <= wn_d;
      bus.address    <= addr_d;
      bus.writedata  <= wd_d;
    end
  end

  assign busy = (state_q != IDLE) && (state_q != RUN);

`ifdef TIMER_CTL_SNAPSHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap_hi_ld;
      if (snap_lo_ld) snapshot[15:0]  <= bus.readdata;
      if (snap_hi_ld) snapshot[31:16] <= bus.readdata;
    end
  end
`else
  logic unused_snap;
  assign unused_snap = ^{bus.readdata, snap_req, snap_lo_ld, snap_hi_ld};
  assign snapshot    = '0;
  assign snap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_nios_practica_timer_ctl_master.sv
module tb_nios_practica_timer_ctl_master;
  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_TK = 2'd2, EV_SV = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, snap_req;
  logic [31:0] period;
  logic        busy, running, tick, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snapshot;

  logic        start_os;
  logic [31:0] period_os;
  logic        busy_os, running_os, tick_os, snap_valid_os;
  logic [15:0] tick_count_os;
  logic [31:0] snapshot_os;

  logic        irq_set;
  logic        clr_pend;
  logic [31:0] snap_mem;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];

  nios_practica_timer_ctl_master_if bus();
  nios_practica_timer_ctl_master_if bus_os();

  nios_practica_timer_ctl_master #(.TICK_W(16), .CONTINUOUS(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .period(period), .stop(stop),
    .snap_req(snap_req), .bus(bus), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snapshot(snapshot),
    .snap_valid(snap_valid));

  nios_practica_timer_ctl_master #(.TICK_W(16), .CONTINUOUS(1'b0)) u_os (
    .clk(clk), .reset(reset), .start(start_os), .period(period_os),
    .stop(1'b0), .snap_req(1'b0), .bus(bus_os), .busy(busy_os),
    .running(running_os), .tick(tick_os), .tick_count(tick_count_os),
    .snapshot(snapshot_os), .snap_valid(snap_valid_os));

  always #5 clk = ~clk;

  assign bus_os.readdata = 16'h0;

  // Timer slave model: irq raised by stimulus, dropped two edges after the
  // status write (one cycle later than the fastest timer), snapshot latch
  // on a write to addr 4, registered readdata.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.irq      <= 1'b0;
      bus.readdata <= 16'h0;
      clr_pend     <= 1'b0;
      snap_mem     <= 32'h0;
    end else begin
      clr_pend <= 1'b0;
      if (irq_set)       bus.irq <= 1'b1;
      else if (clr_pend) bus.irq <= 1'b0;
      if (bus.chipselect && !bus.write_n && bus.address == 3'd0) clr_pend <= 1'b1;
      if (bus.chipselect && !bus.write_n && bus.address == 3'd4) snap_mem <= 32'h0001_2345;
      if (bus.chipselect && bus.write_n)
        bus.readdata <= (bus.address == 3'd5) ? snap_mem[31:16] : snap_mem[15:0];
      else
        bus.readdata <= 16'h0;
    end
  end

  task automatic push(input logic [1:0] k, input logic [2:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [1:0] k, input logic [2:0] a, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=0x%0h, required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        n_bad++;
        $display("FAIL bus_event: got kind=%0d addr=%0d data=0x%0h, required kind=%0d addr=%0d data=0x%0h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every bus cycle, tick pulse and snapshot pulse is one event.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.chipselect)
        got(bus.write_n ? EV_RD : EV_WR, bus.address,
            {16'h0, bus.write_n ? 16'h0 : bus.writedata});
      if (tick)       got(EV_TK, 3'd0, {16'h0, tick_count});
      if (snap_valid) got(EV_SV, 3'd0, snapshot);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; snap_req = 1'b0; period = 32'h0;
    irq_set = 1'b0; start_os = 1'b0; period_os = 32'h0; bus_os.irq = 1'b0;
    cyc(2);
    chk("rst_bus", {bus.chipselect, bus.write_n, bus.address, bus.writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    chk("rst_flags", {busy, running, tick, snap_valid}, 4'b0000);
    chk("rst_tick_count", tick_count, 0);
    chk("rst_snapshot", snapshot, 0);
    reset = 1'b0;
    cyc(1);

    // start with period 9
    push(EV_WR, 2, 32'h9); push(EV_WR, 3, 32'h0); push(EV_WR, 1, 32'h7);
    period = 32'd9; start = 1'b1; cyc(1); start = 1'b0;
    chk("busy_programming", busy, 1);
    cyc(3);
    chk("running_after_ctl", {running, busy}, 2'b10);

    // five timeouts, each: status clear write + tick with the new count
    for (int i = 1; i <= 5; i++) begin
      cyc(10);
      push(EV_WR, 0, 32'h0); push(EV_TK, 0, i);
      irq_set = 1'b1; cyc(1); irq_set = 1'b0;
    end
    cyc(6);
    chk("tick_count_5", tick_count, 5);

`ifdef TIMER_CTL_SNAPSHOT_EN
    push(EV_WR, 4, 32'h0); push(EV_RD, 4, 32'h0); push(EV_RD, 5, 32'h0);
    push(EV_SV, 0, 32'h0001_2345); push(EV_WR, 0, 32'h0); push(EV_TK, 0, 6);
    snap_req = 1'b1; cyc(1); snap_req = 1'b0;
    irq_set = 1'b1; cyc(1); irq_set = 1'b0;
    cyc(12);
    chk("snapshot_val", snapshot, 32'h0001_2345);
    chk("tick_count_after_snap", tick_count, 6);
    chk("running_after_snap", running, 1);
`else
    snap_req = 1'b1; cyc(1); snap_req = 1'b0;
    cyc(8);
    chk("snapshot_tied", snapshot, 0);
    chk("snap_ignored_busy", busy, 0);
    chk("tick_count_kept", tick_count, 5);
`endif

    // restart in RUN with a new period: count clears
    push(EV_WR, 2, 32'h5); push(EV_WR, 3, 32'h2); push(EV_WR, 1, 32'h7);
    period = 32'h0002_0005; start = 1'b1; cyc(1); start = 1'b0;
    chk("restart_count_clr", tick_count, 0);
    cyc(3);
    chk("restart_running", running, 1);

    // one timeout, then stop: no tick during the stop's clear
    cyc(5);
    push(EV_WR, 0, 32'h0); push(EV_TK, 0, 1);
    irq_set = 1'b1; cyc(1); irq_set = 1'b0;
    cyc(6);
    push(EV_WR, 1, 32'h8); push(EV_WR, 0, 32'h0);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("stop_running_clr", running, 0);
    cyc(1);
    chk("stop_clr_busy", busy, 1);
    cyc(1);
    chk("stop_idle", {busy, running}, 2'b00);
    chk("stop_count_kept", tick_count, 1);

    // stop in IDLE is ignored
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(3);
    chk("stop_idle_ignored", busy, 0);

    // reset in the middle of WR_PH
    push(EV_WR, 2, 32'h11);
    period = 32'h11; start = 1'b1; cyc(1); start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("midrst_bus_idle", {bus.chipselect, bus.write_n, bus.address, bus.writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    chk("midrst_state", {busy, running, tick_count}, 18'h0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    push(EV_WR, 2, 32'h33); push(EV_WR, 3, 32'h0); push(EV_WR, 1, 32'h7);
    period = 32'h33; start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    chk("reprog_running", running, 1);

    // one-shot instance: single timeout returns to IDLE
    period_os = 32'd4; start_os = 1'b1; cyc(1); start_os = 1'b0;
    cyc(3);
    chk("os_running", running_os, 1);
    chk("os_ctl_cont0", bus_os.writedata, 16'h0);
    bus_os.irq = 1'b1; cyc(1); bus_os.irq = 1'b0;
    chk("os_clr_write", {bus_os.chipselect, bus_os.write_n, bus_os.address, bus_os.writedata}, {1'b1, 1'b0, 3'd0, 16'h0});
    chk("os_tick", {tick_os, tick_count_os}, {1'b1, 16'd1});
    cyc(1);
    chk("os_idle", {running_os, busy_os, tick_os}, 3'b000);

    cyc(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
